// File: rtl/bsg_manycore_pl_to_ps_packet_arbiter.sv
// Purpose: round-robin, packet-atomic merge of several wide manycore packet streams onto one narrow PL-to-PS FIFO channel, with per-source delivered-packet counters.
// Latency: a packet accepted in cycle t presents its first word in t+1 and its last word in t+els_lp when the FIFO never stalls; one IDLE cycle separates packets.
// Backpressure: fifo_ready_i low freezes the word being presented; sources see ready only in IDLE, so a stalled FIFO holds every source off.
module bsg_manycore_pl_to_ps_packet_arbiter #(
  parameter int num_src_p    = 2,
  parameter int fifo_width_p = 128,
  parameter int data_width_p = 32,
  localparam int els_lp      = (fifo_width_p + data_width_p - 1) / data_width_p,
  localparam int id_width_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,

  input  logic [num_src_p*fifo_width_p-1:0] src_data_i,
  input  logic [num_src_p-1:0]              src_v_i,
  output logic [num_src_p-1:0]              src_ready_o,

  output logic [data_width_p-1:0]           fifo_data_o,
  output logic                              fifo_v_o,
  input  logic                              fifo_ready_i,
  output logic [id_width_lp-1:0]            fifo_src_id_o,
  output logic                              fifo_last_o,

  output logic [num_src_p*32-1:0]           pkt_count_o
);

  // The shift register is padded up to a whole number of words so the
  // final word of a non-multiple packet carries zeros in its upper bits.
  localparam int shift_width_lp = els_lp * data_width_p;
  localparam int cnt_width_lp   = (els_lp > 1) ? $clog2(els_lp) : 1;

  localparam logic [0:0] idle_s = 1'b0;
  localparam logic [0:0] send_s = 1'b1;

  logic [0:0]                    state_r;
  logic [shift_width_lp-1:0]     shift_r;
  logic [cnt_width_lp-1:0]       cnt_r;
  logic [id_width_lp-1:0]        src_id_r;
  logic [id_width_lp-1:0]        last_grant_r;
  logic [num_src_p-1:0][31:0]    pkt_count_r;

  logic                          grant_v;
  logic [id_width_lp-1:0]        grant_id;
  logic [id_width_lp-1:0]        cand;
  logic [fifo_width_p-1:0]       grant_pkt;
  logic                          accept;
  logic                          last_word;
  logic                          word_xfer;
  logic                          pkt_done;

  // Round-robin search: start one past the previous winner and wrap, first valid source wins.
  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    cand     = '0;
    for (int i = 1; i <= num_src_p; i++) begin
      cand = id_width_lp'((int'(last_grant_r) + i) % num_src_p);
      if (!grant_v && src_v_i[cand]) begin
        grant_v  = 1'b1;
        grant_id = cand;
      end
    end
  end

  // Select the winning source's packet for capture.
  always_comb begin
    grant_pkt = '0;
    for (int i = 0; i < num_src_p; i++) begin
      if (grant_id == id_width_lp'(i)) begin
        grant_pkt = src_data_i[i*fifo_width_p +: fifo_width_p];
      end
    end
  end

  assign accept    = (state_r == idle_s) && grant_v && !reset_i;
  assign last_word = (cnt_r == cnt_width_lp'(els_lp - 1));
  assign word_xfer = (state_r == send_s) && fifo_ready_i;
  assign pkt_done  = word_xfer && last_word;

  // One-hot ready for the winner only, and only while idle and out of reset.
  always_comb begin
    src_ready_o = '0;
    if (accept) begin
      src_ready_o = num_src_p'(1) << grant_id;
    end
  end

  // Packet FSM: capture in IDLE, shift one word out per FIFO transfer in SEND.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= idle_s;
      shift_r      <= '0;
      cnt_r        <= '0;
      src_id_r     <= '0;
      last_grant_r <= id_width_lp'(num_src_p - 1);
    end else begin
      case (state_r)
        idle_s: begin
          if (grant_v) begin
            shift_r      <= shift_width_lp'(grant_pkt);
            cnt_r        <= '0;
            src_id_r     <= grant_id;
            last_grant_r <= grant_id;
            state_r      <= send_s;
          end
        end
        send_s: begin
          if (fifo_ready_i) begin
            shift_r <= shift_r >> data_width_p;
            cnt_r   <= cnt_r + 1'b1;
            if (last_word) begin
              state_r <= idle_s;
            end
          end
        end
        default: state_r <= idle_s;
      endcase
    end
  end

  // Delivered-packet counters bump only when the final word actually leaves.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pkt_count_r <= '0;
    end else if (pkt_done) begin
      pkt_count_r[src_id_r] <= pkt_count_r[src_id_r] + 32'd1;
    end
  end

  // Outputs toward the FIFO come straight from state; the shift register is
  // zero whenever IDLE, so the data bus reads zero between packets.
  assign fifo_v_o      = (state_r == send_s);
  assign fifo_data_o   = shift_r[data_width_p-1:0];
  assign fifo_last_o   = (state_r == send_s) && last_word;
  assign fifo_src_id_o = src_id_r;
  assign pkt_count_o   = pkt_count_r;

endmodule

// File: tb/tb_bsg_manycore_pl_to_ps_packet_arbiter.sv
// Purpose: self-checking bench for the PL-to-PS packet arbiter against a queue-based reference model.
// Latency: model predicts outputs every cycle; checks sample 1 time unit after the falling edge.
// Backpressure: fifo_ready_i is driven directly by the stimulus (fixed or random).
module tb_bsg_manycore_pl_to_ps_packet_arbiter;

  localparam int N   = 2;
  localparam int FW  = 128;
  localparam int DW  = 32;
  localparam int ELS = 4;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [N*FW-1:0] src_data;
  logic [N-1:0]    src_v;
  logic [N-1:0]    src_ready;
  logic [DW-1:0]   fifo_data;
  logic            fifo_v;
  logic            fifo_ready;
  logic [0:0]      fifo_src_id;
  logic            fifo_last;
  logic [N*32-1:0] pkt_count;

  always #5 clk = ~clk;

  bsg_manycore_pl_to_ps_packet_arbiter #(
    .num_src_p   (N),
    .fifo_width_p(FW),
    .data_width_p(DW)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .src_data_i   (src_data),
    .src_v_i      (src_v),
    .src_ready_o  (src_ready),
    .fifo_data_o  (fifo_data),
    .fifo_v_o     (fifo_v),
    .fifo_ready_i (fifo_ready),
    .fifo_src_id_o(fifo_src_id),
    .fifo_last_o  (fifo_last),
    .pkt_count_o  (pkt_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of words still owed for the packet in flight,
  // the last winner, and the delivered count per source.
  logic [DW-1:0]  m_q[$];
  int             m_src;
  int             m_last_grant;
  logic [31:0]    m_cnt[N];

  logic [100:0]   obs_b;
  logic [100:0]   exp_b;

  function automatic logic [FW-1:0] rand_pkt();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Who would win right now: first valid source after the last winner, wrapping.
  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      int s;
      s = (m_last_grant + k) % N;
      if (src_v[s]) return s;
    end
    return -1;
  endfunction

  // Build the observed and predicted output bundles for the current cycle.
  task automatic sample();
    logic [N-1:0]  e_rdy;
    logic          e_v;
    logic          e_last;
    logic [DW-1:0] e_data;
    int            g;
    e_rdy  = '0;
    e_v    = 1'b0;
    e_last = 1'b0;
    e_data = '0;
    if (m_q.size() > 0) begin
      e_v    = 1'b1;
      e_last = (m_q.size() == 1);
      e_data = m_q[0];
    end else if (!reset_i) begin
      g = rr_pick();
      if (g >= 0) e_rdy[g] = 1'b1;
    end
    exp_b = {m_cnt[1], m_cnt[0], e_rdy, e_v, e_last, 1'(m_src), e_data};
    obs_b = {pkt_count, src_ready, fifo_v, fifo_last, fifo_src_id, fifo_data};
  endtask

  // Advance the model across the coming rising edge using the driven inputs.
  task automatic model_step();
    int g;
    if (reset_i) begin
      m_q.delete();
      m_src        = 0;
      m_last_grant = N - 1;
      for (int i = 0; i < N; i++) m_cnt[i] = '0;
    end else if (m_q.size() > 0) begin
      if (fifo_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_cnt[m_src] = m_cnt[m_src] + 32'd1;
      end
    end else begin
      g = rr_pick();
      if (g >= 0) begin
        logic [FW-1:0] p;
        p = src_data[g*FW +: FW];
        for (int w = 0; w < ELS; w++) m_q.push_back(p[w*DW +: DW]);
        m_src        = g;
        m_last_grant = g;
      end
    end
  endtask

  // One reset cycle; the caller's next drive releases it.
  task automatic do_reset();
    @(negedge clk);
    reset_i    = 1'b1;
    src_v      = '0;
    fifo_ready = 1'b0;
    #1;
    model_step();
  endtask

  task automatic test_reset();
    reset_i    = 1'b1;
    src_v      = 2'b11;
    fifo_ready = 1'b1;
    src_data   = {rand_pkt(), rand_pkt()};
    model_step();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      sample();
      checks++;
      if (obs_b !== exp_b) begin
        errors++;
        $display("FAIL reset_state cyc %0d: dut=%h model=%h", c, obs_b, exp_b);
      end
      checks++;
      if (src_ready !== 2'b00 || fifo_v !== 1'b0 || fifo_last !== 1'b0 || fifo_data !== 32'h0 || pkt_count !== 64'h0) begin
        errors++;
        $display("FAIL reset_values cyc %0d: ready=%b v=%b last=%b data=%h cnt=%h, want all zero", c, src_ready, fifo_v, fifo_last, fifo_data, pkt_count);
      end
      model_step();
    end
  endtask

  task automatic test_single();
    logic [31:0] wds [4];
    wds = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    do_reset();
    @(negedge clk);
    reset_i    = 1'b0;
    src_v      = 2'b01;
    fifo_ready = 1'b1;
    src_data   = {rand_pkt(), 128'h44444444_33333333_22222222_11111111};
    #1;
    checks++;
    if (src_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_grant: ready=%b want 01", src_ready);
    end
    sample();
    checks++;
    if (obs_b !== exp_b) begin
      errors++;
      $display("FAIL single_model cyc 0: dut=%h model=%h", obs_b, exp_b);
    end
    model_step();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      src_v = 2'b00;
      #1;
      checks++;
      if (k <= 4) begin
        if (fifo_v !== 1'b1 || fifo_data !== wds[k-1] || fifo_last !== 1'(k == 4) || src_ready !== 2'b00) begin
          errors++;
          $display("FAIL single_word %0d: v=%b data=%h last=%b ready=%b, want 1 %h %b 00", k, fifo_v, fifo_data, fifo_last, src_ready, wds[k-1], 1'(k == 4));
        end
      end else begin
        if (fifo_v !== 1'b0 || fifo_src_id !== 1'b0 || pkt_count[31:0] !== 32'd1) begin
          errors++;
          $display("FAIL single_done: v=%b id=%b cnt0=%0d, want 0 0 1", fifo_v, fifo_src_id, pkt_count[31:0]);
        end
      end
      sample();
      checks++;
      if (obs_b !== exp_b) begin
        errors++;
        $display("FAIL single_model cyc %0d: dut=%h model=%h", k, obs_b, exp_b);
      end
      model_step();
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      reset_i    = 1'b0;
      src_v      = (c < 16) ? 2'b11 : 2'b00;
      fifo_ready = 1'b1;
      src_data   = {rand_pkt(), rand_pkt()};
      #1;
      if (src_ready !== 2'b00) order.push_back(src_ready[1] ? 1 : 0);
      sample();
      checks++;
      if (obs_b !== exp_b) begin
        errors++;
        $display("FAIL rr_model cyc %0d: dut=%h model=%h", c, obs_b, exp_b);
      end
      model_step();
    end
    checks++;
    if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
      errors++;
      $display("FAIL rr_order: got %0d grants %p, want 0,1,0,1", order.size(), order);
    end
    checks++;
    if (pkt_count !== {32'd2, 32'd2}) begin
      errors++;
      $display("FAIL rr_counts: got %h want {2,2}", pkt_count);
    end
  endtask

  task automatic test_backpressure();
    logic          hold;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    hold      = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      reset_i    = 1'b0;
      src_v      = 2'($urandom);
      fifo_ready = 1'($urandom % 2);
      src_data   = {rand_pkt(), rand_pkt()};
      #1;
      if (hold) begin
        checks++;
        if (fifo_v !== 1'b1 || fifo_data !== prev_data || fifo_last !== prev_last) begin
          errors++;
          $display("FAIL bp_hold cyc %0d: v=%b data=%h last=%b, want 1 %h %b", c, fifo_v, fifo_data, fifo_last, prev_data, prev_last);
        end
      end
      if (fifo_v === 1'b1) begin
        checks++;
        if (src_ready !== 2'b00) begin
          errors++;
          $display("FAIL bp_ready_in_send cyc %0d: ready=%b want 00", c, src_ready);
        end
      end
      sample();
      checks++;
      if (obs_b !== exp_b) begin
        errors++;
        $display("FAIL bp_model cyc %0d: dut=%h model=%h", c, obs_b, exp_b);
      end
      hold      = fifo_v && !fifo_ready;
      prev_data = fifo_data;
      prev_last = fifo_last;
      model_step();
    end
  endtask

  task automatic test_only_src1();
    int g0;
    int g1;
    g0 = 0;
    g1 = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      reset_i    = 1'b0;
      src_v      = (c < 11) ? 2'b10 : 2'b00;
      fifo_ready = 1'b1;
      src_data   = {rand_pkt(), rand_pkt()};
      #1;
      if (src_ready[0] === 1'b1) g0++;
      if (src_ready[1] === 1'b1) g1++;
      sample();
      checks++;
      if (obs_b !== exp_b) begin
        errors++;
        $display("FAIL src1_model cyc %0d: dut=%h model=%h", c, obs_b, exp_b);
      end
      model_step();
    end
    checks++;
    if (g1 != 3 || g0 != 0 || pkt_count[63:32] !== 32'd3) begin
      errors++;
      $display("FAIL src1_only: grants1=%0d grants0=%0d cnt1=%0d, want 3 0 3", g1, g0, pkt_count[63:32]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      reset_i    = (c == 8);
      src_v      = (c < 5) ? 2'b10 : 2'b11;
      fifo_ready = 1'b1;
      src_data   = {rand_pkt(), rand_pkt()};
      #1;
      if (c == 8) begin
        checks++;
        if (src_ready !== 2'b00 || pkt_count[63:32] !== 32'd1) begin
          errors++;
          $display("FAIL rstmid_during: ready=%b cnt1=%0d, want 00 1", src_ready, pkt_count[63:32]);
        end
      end
      if (c == 9) begin
        checks++;
        if (fifo_v !== 1'b0 || fifo_last !== 1'b0 || pkt_count !== 64'h0 || src_ready !== 2'b01) begin
          errors++;
          $display("FAIL rstmid_after: v=%b last=%b cnt=%h ready=%b, want 0 0 0 01", fifo_v, fifo_last, pkt_count, src_ready);
        end
      end
      sample();
      checks++;
      if (obs_b !== exp_b) begin
        errors++;
        $display("FAIL rstmid_model cyc %0d: dut=%h model=%h", c, obs_b, exp_b);
      end
      model_step();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      reset_i    = 1'b0;
      src_v      = (c == 0) ? 2'b01 : 2'b00;
      fifo_ready = 1'b1;
      src_data   = {rand_pkt(), rand_pkt()};
      if (c == 0) begin
        dut.pkt_count_r[0] = 32'hFFFF_FFFF;
        dut.pkt_count_r[1] = 32'h1234_5678;
        m_cnt[0] = 32'hFFFF_FFFF;
        m_cnt[1] = 32'h1234_5678;
      end
      #1;
      sample();
      checks++;
      if (obs_b !== exp_b) begin
        errors++;
        $display("FAIL wrap_model cyc %0d: dut=%h model=%h", c, obs_b, exp_b);
      end
      model_step();
    end
    checks++;
    if (pkt_count[31:0] !== 32'h0 || pkt_count[63:32] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL wrap_count: cnt0=%h cnt1=%h, want 00000000 12345678", pkt_count[31:0], pkt_count[63:32]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      reset_i    = ($urandom_range(0, 299) == 0);
      src_v      = 2'($urandom);
      fifo_ready = ($urandom_range(0, 3) != 0);
      src_data   = {rand_pkt(), rand_pkt()};
      #1;
      sample();
      checks++;
      if (obs_b !== exp_b) begin
        errors++;
        $display("FAIL random_model cyc %0d: dut=%h model=%h", c, obs_b, exp_b);
      end
      model_step();
    end
  endtask

  initial begin
    m_src        = 0;
    m_last_grant = N - 1;
    for (int i = 0; i < N; i++) m_cnt[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_only_src1();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
